// File: rtl/burp_fetch_if.sv
// Fetch-sequencer bus: ROM port, ALU carry and execute-stage valid/ready handshake.
interface burp_fetch_if;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       carry;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump_taken;

    modport master (
        output rom_addr, instr, instr_valid, jump_taken,
        input  rom_data, carry, instr_ready
    );

    modport slave (
        input  rom_addr, instr, instr_valid, jump_taken,
        output rom_data, carry, instr_ready
    );
endinterface

// File: rtl/burp_fetch.sv
// BURP instruction fetch sequencer: owns the PC, resolves JMP/JC locally and
// issues every other instruction to execute over a single-outstanding valid/ready.
module burp_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] OP_JC    = 4'b1111,
    parameter logic [3:0] OP_JMP   = 4'b1110
) (
    input  logic          clk,
    input  logic          rst_n,
    burp_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        TARGET = 2'd1,
        ISSUE  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       valid_q, valid_d;
    logic       jump_q, jump_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            valid_q <= 1'b0;
            jump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            jump_q  <= jump_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        jump_d  = 1'b0;
        unique case (state_q)
            FETCH: begin
                ir_d = bus.rom_data;
                pc_d = pc_q + 8'd1;
                if (bus.rom_data[7:4] == OP_JMP || bus.rom_data[7:4] == OP_JC) begin
                    state_d = TARGET;
                end else begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                end
            end
            TARGET: begin
                // ir still holds the jump opcode; rom_data is the target byte.
                if (ir_q[7:4] == OP_JMP || bus.carry) begin
                    pc_d   = bus.rom_data;
                    jump_d = 1'b1;
                end else begin
                    pc_d = pc_q + 8'd1;
                end
                state_d = FETCH;
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign bus.rom_addr    = pc_q;
    assign bus.instr       = ir_q;
    assign bus.instr_valid = valid_q;
    assign bus.jump_taken  = jump_q;

endmodule
